// File: rtl/sr_sync_fifo.sv
// sr_sync_fifo: single-clock FIFO with count, almost flags, flush and sticky errors.
// Define SR_FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads are registered.
module sr_sync_fifo #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 3,
    parameter int AFULL_LEVEL  = 6,
    parameter int AEMPTY_LEVEL = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  writeEnable,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic                  readEnable,
    output logic [DATA_WIDTH-1:0] readData,
    output logic                  readValid,
    output logic                  full,
    output logic                  empty,
    output logic                  almostFull,
    output logic                  almostEmpty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   AF_CNT   = AFULL_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   AE_CNT   = AEMPTY_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = 1;

    if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_bad_afull
        $error("AFULL_LEVEL out of range");
    end
    if (AEMPTY_LEVEL < 0 || AEMPTY_LEVEL > DEPTH - 1) begin : g_bad_aempty
        $error("AEMPTY_LEVEL out of range");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]   cnt_nxt;
    logic                  wr_ok, rd_ok;

    assign full        = count == FULL_CNT;
    assign empty       = count == '0;
    assign almostFull  = count >= AF_CNT;
    assign almostEmpty = count <= AE_CNT;

    // A full FIFO still takes a write when a read frees the head slot in the same cycle.
    assign wr_ok = writeEnable & (!full | readEnable);
    assign rd_ok = readEnable & !empty;

    always_comb begin
        cnt_nxt = (wr_ok & !rd_ok) ? count + CNT_ONE :
                  (rd_ok & !wr_ok) ? count - CNT_ONE : count;
    end

    always_ff @(posedge clk) begin
        if (reset && !flush && wr_ok)
            mem[wr_ptr] <= writeData;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_ok)
                rd_ptr <= rd_ptr + PTR_ONE;
            count <= cnt_nxt;
            if (writeEnable && full && !readEnable)
                overflow <= 1'b1;
            if (readEnable && empty)
                underflow <= 1'b1;
        end
    end

`ifdef SR_FIFO_FWFT_EN
    assign readData  = empty ? '0 : mem[rd_ptr];
    assign readValid = !empty;
`else
    // readData is deliberately left untouched by flush; only the strobe drops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            readData  <= '0;
            readValid <= 1'b0;
        end else begin
            readValid <= !flush && rd_ok;
            if (!flush && rd_ok)
                readData <= mem[rd_ptr];
        end
    end
`endif

endmodule

// File: tb/tb_sr_sync_fifo.sv
// tb_sr_sync_fifo: directed checks of sr_sync_fifo in its default registered-read build.
module tb_sr_sync_fifo;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        writeEnable = 1'b0;
    logic [31:0] writeData = '0;
    logic        readEnable = 1'b0;
    logic [31:0] readData;
    logic        readValid, full, empty, almostFull, almostEmpty, overflow, underflow;
    logic [3:0]  count;
    int total = 0;
    int bad = 0;

    sr_sync_fifo dut (
        .clk(clk), .reset(reset), .flush(flush),
        .writeEnable(writeEnable), .writeData(writeData), .readEnable(readEnable),
        .readData(readData), .readValid(readValid), .full(full), .empty(empty),
        .almostFull(almostFull), .almostEmpty(almostEmpty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus; outputs are sampled 1ns after the edge.
    task automatic cyc(input logic we, input logic [31:0] wd, input logic re, input logic fl);
        writeEnable = we;
        writeData   = wd;
        readEnable  = re;
        flush       = fl;
        @(posedge clk);
        #1;
        writeEnable = 1'b0;
        readEnable  = 1'b0;
        flush       = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_rdata", readData, 0);
        chk("rst_rvalid", 32'(readValid), 0);
        chk("rst_aempty", 32'(almostEmpty), 1);
        chk("rst_afull", 32'(almostFull), 0);
        chk("rst_errs", {30'd0, overflow, underflow}, 0);
        @(negedge clk);
        reset = 1'b1;

        cyc(1, 32'h11, 0, 0);
        chk("ae_one", 32'(almostEmpty), 1);
        cyc(1, 32'h22, 0, 0);
        chk("ae_two", 32'(almostEmpty), 0);
        cyc(1, 32'h33, 0, 0);
        chk("cnt3", 32'(count), 3);
        cyc(0, 0, 1, 0);
        chk("pop11", readData, 32'h11);
        chk("pop11_v", 32'(readValid), 1);
        cyc(0, 0, 1, 0);
        chk("pop22", readData, 32'h22);
        cyc(0, 0, 1, 0);
        chk("pop33", readData, 32'h33);
        chk("pop33_v", 32'(readValid), 1);
        chk("drained", 32'(empty), 1);
        cyc(0, 0, 0, 0);
        chk("idle_v", 32'(readValid), 0);
        chk("idle_hold", readData, 32'h33);

        for (int i = 0; i < 8; i++) begin
            cyc(1, 32'hA0 + 32'(i), 0, 0);
            chk($sformatf("afull_%0d", i + 1), 32'(almostFull), (i + 1 >= 6) ? 1 : 0);
        end
        chk("full8", 32'(full), 1);
        chk("cnt8", 32'(count), 8);
        cyc(1, 32'hFF, 0, 0);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_cnt", 32'(count), 8);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 1, 0);
            chk($sformatf("drain_%0d", i), readData, 32'hA0 + 32'(i));
        end
        chk("drain_empty", 32'(empty), 1);
        cyc(0, 0, 0, 0);
        chk("ovf_sticky", 32'(overflow), 1);
        cyc(0, 0, 0, 1);
        chk("flush_ovf", 32'(overflow), 0);

        for (int i = 0; i < 8; i++)
            cyc(1, 32'hA0 + 32'(i), 0, 0);
        cyc(1, 32'hB0, 1, 0);
        chk("frw_data", readData, 32'hA0);
        chk("frw_valid", 32'(readValid), 1);
        chk("frw_cnt", 32'(count), 8);
        chk("frw_ovf", 32'(overflow), 0);
        for (int i = 1; i < 8; i++) begin
            cyc(0, 0, 1, 0);
            chk($sformatf("frw_pop_%0d", i), readData, 32'hA0 + 32'(i));
        end
        cyc(0, 0, 1, 0);
        chk("frw_b0", readData, 32'hB0);
        chk("frw_empty", 32'(empty), 1);

        cyc(1, 32'hC5, 1, 0);
        chk("erw_unf", 32'(underflow), 1);
        chk("erw_valid", 32'(readValid), 0);
        chk("erw_cnt", 32'(count), 1);
        chk("erw_hold", readData, 32'hB0);
        cyc(0, 0, 1, 0);
        chk("erw_c5", readData, 32'hC5);
        chk("erw_c5_v", 32'(readValid), 1);

        for (int i = 0; i < 20; i++) begin
            cyc(1, 32'(i), 0, 0);
            chk($sformatf("wrap_cnt_%0d", i), 32'(count), 1);
            cyc(0, 0, 1, 0);
            chk($sformatf("wrap_dat_%0d", i), readData, 32'(i));
        end

        for (int i = 0; i < 5; i++)
            cyc(1, 32'hD0 + 32'(i), 0, 0);
        chk("pre_flush_cnt", 32'(count), 5);
        cyc(1, 32'h77, 0, 1);
        chk("fl_cnt", 32'(count), 0);
        chk("fl_empty", 32'(empty), 1);
        chk("fl_errs", {30'd0, overflow, underflow}, 0);
        chk("fl_valid", 32'(readValid), 0);
        chk("fl_hold", readData, 32'd19);
        cyc(0, 0, 1, 0);
        chk("fl_discard", 32'(underflow), 1);
        cyc(1, 32'h5A, 0, 0);
        cyc(0, 0, 1, 0);
        chk("fl_first", readData, 32'h5A);

        cyc(1, 32'h61, 0, 0);
        cyc(1, 32'h62, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_cnt", 32'(count), 0);
        chk("mid_rst_empty", 32'(empty), 1);
        chk("mid_rst_rdata", readData, 0);
        chk("mid_rst_unf", 32'(underflow), 0);
        @(negedge clk);
        reset = 1'b1;
        cyc(1, 32'h66, 0, 0);
        chk("post_rst_cnt", 32'(count), 1);
        cyc(0, 0, 1, 0);
        chk("post_rst_data", readData, 32'h66);
        chk("post_rst_v", 32'(readValid), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sr_sync_fifo.md
Name: sr_sync_fifo

Overview:
Parametrised synchronous single-clock FIFO for the core's I/O and peripheral paths.
- Supports a read and a write in the same cycle, including when full.
- Exposes full/empty, almost-full/almost-empty, occupancy count, a synchronous flush, and sticky overflow/underflow error flags.
- Read side is either registered (1-cycle latency with valid strobe) or first-word-fall-through, selected at compile time.

Parameters:
DATA_WIDTH, 32, width of each stored word
ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH entries (default 8)
AFULL_LEVEL, 6, almostFull asserts when count >= AFULL_LEVEL (range 1..DEPTH)
AEMPTY_LEVEL, 1, almostEmpty asserts when count <= AEMPTY_LEVEL (range 0..DEPTH-1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
flush  input  1  synchronous clear of contents and error flags
writeEnable  input  1  push request
writeData  input  DATA_WIDTH  push data
readEnable  input  1  pop request
readData  output  DATA_WIDTH  popped word (registered mode) or head word (FWFT mode)
readValid  output  1  readData holds a newly popped word
full  output  1  count == DEPTH
empty  output  1  count == 0
almostFull  output  1  count >= AFULL_LEVEL
almostEmpty  output  1  count <= AEMPTY_LEVEL
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a write was dropped
underflow  output  1  sticky: a read was dropped

Behaviour:
- Reset (reset low, asynchronous):
  - Pointers and count = 0; readData = 0; readValid = 0; overflow = underflow = 0.
  - Therefore empty = 1, full = 0, almostEmpty = 1, almostFull = 0.
  - Memory contents are not reset.
- State: writePtr and readPtr are each ADDR_WIDTH bits and wrap naturally from DEPTH-1 to 0; count is an explicit (ADDR_WIDTH+1)-bit register.
- Status flags (full, empty, almostFull, almostEmpty) are combinational decodes of count, so they update in the cycle after the causing edge.
- Accept rules, evaluated per cycle:
  - wr_ok = writeEnable & (!full | readEnable).
  - rd_ok = readEnable & !empty.
- Accepted write: mem[writePtr] <= writeData; writePtr advances by 1.
- Accepted read:
  - readPtr advances by 1.
  - Registered mode: readData <= mem[readPtr] and readValid = 1 on the next cycle.
  - In every cycle without an accepted read, readValid = 0 and readData holds its value.
- Count update: +1 if wr_ok & !rd_ok; -1 if rd_ok & !wr_ok; unchanged otherwise.
- Full + read + write: both are accepted; the oldest word is popped and the new word is written into the freed slot. Count stays DEPTH.
- Empty + read + write: the write is accepted; the read is dropped and sets underflow. No bypass, so the new word is visible next cycle.
- Dropped write (writeEnable & full & !readEnable): overflow <= 1; memory and pointers are unchanged.
- Dropped read (readEnable & empty): underflow <= 1; readData unchanged; readValid = 0.
- Error flags remain set until flush or reset.
- flush has priority over all other activity in its cycle:
  - Pointers, count, overflow, underflow and readValid are cleared.
  - readData is unchanged in registered mode.
  - Any read or write in the same cycle is ignored and raises no error flag.
- Reset asserted mid-transfer discards all contents immediately; the first operation after release behaves as on an empty FIFO.

Optional Feature:
SR_FIFO_FWFT_EN
- Defined (FWFT mode):
  - readData = mem[readPtr] combinationally when !empty, and 0 when empty.
  - readValid = !empty.
  - readEnable acknowledges the head word; the next word appears in the cycle after the pop.
  - Accept, count, error and flush rules are identical to registered mode.
- Undefined: registered mode as described in Behaviour; read latency is 1 cycle.

Test Plan:
- Reset with no other activity -> empty=1, full=0, count=0, readData=0, readValid=0. Push 0x11, 0x22, 0x33, then pop 3 -> readData sequence 0x11, 0x22, 0x33, each word on the cycle after its pop with readValid=1, then empty=1.
- Push 8 words 0xA0..0xA7 -> full=1 and count=8; almostFull first asserts after the 6th push. A 9th push of 0xFF -> overflow=1, count=8; popping all 8 returns 0xA0..0xA7 and 0xFF never appears.
- Full FIFO, readEnable and writeEnable together with 0xB0 -> readData=0xA0, count stays 8, overflow stays 0; the 8th following pop returns 0xB0.
- Empty FIFO, read and write of 0xC5 together -> underflow=1, readValid=0, count=1; next pop returns 0xC5.
- Wrap-around: 20 interleaved push/pop pairs of the values 0..19 -> output order exactly 0..19, count never exceeds 1.
- Load 5 words, then assert flush together with a push -> count=0, empty=1, error flags cleared, pushed word discarded. With SR_FIFO_FWFT_EN, readData=0 right after the flush and shows the first new word the cycle after its push.
